// File: rtl/pipe_ctrl_pkg.sv
// Shared types and encodings for the pipeline hazard controller.
// Forward selects name the stage that supplies the E-stage operand.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } hz_state_t;

    localparam logic [1:0] FWD_REG      = 2'b00;
    localparam logic [1:0] FWD_M        = 2'b10;
    localparam logic [1:0] FWD_W        = 2'b01;
    localparam logic [1:0] RES_SRC_LOAD = 2'b01;

endpackage

// File: rtl/pipe_hazard_controller_fwd.sv
// E-stage operand forwarding: a matching M producer beats a matching W producer.
// Index 0 is the scalar x0 and never forwards.
module forwarding_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W = 6
) (
    input  logic [REG_W-1:0] r1_E,
    input  logic [REG_W-1:0] r2_E,
    input  logic [REG_W-1:0] rd_M,
    input  logic [REG_W-1:0] rd_W,
    input  logic             write_reg_M,
    input  logic             write_reg_W,
    output logic [1:0]       forward_0_E,
    output logic [1:0]       forward_1_E
);

    function automatic logic [1:0] fwd_sel(
        input logic [REG_W-1:0] src,
        input logic [REG_W-1:0] dm,
        input logic             wm,
        input logic [REG_W-1:0] dw,
        input logic             ww
    );
        logic [1:0] sel;
        sel = FWD_REG;
        if (src != '0 && src == dm && wm) begin
            sel = FWD_M;
        end else if (src != '0 && src == dw && ww) begin
            sel = FWD_W;
        end
        return sel;
    endfunction

    always_comb begin
        forward_0_E = fwd_sel(r1_E, rd_M, write_reg_M, rd_W, write_reg_W);
        forward_1_E = fwd_sel(r2_E, rd_M, write_reg_M, rd_W, write_reg_W);
    end

endmodule

// File: rtl/pipe_hazard_controller.sv
// Stall/flush control for the F/D/E/M pipe registers plus E-stage forwarding.
// A memory wait freezes the whole pipe; a wait that never ends latches an error.
module pipe_hazard_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W       = 6,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clock,
    input  logic             sync_reset,
    input  logic [REG_W-1:0] r1_D,
    input  logic [REG_W-1:0] r2_D,
    input  logic [REG_W-1:0] r1_E,
    input  logic [REG_W-1:0] r2_E,
    input  logic [REG_W-1:0] rd_E,
    input  logic [REG_W-1:0] rd_M,
    input  logic [REG_W-1:0] rd_W,
    input  logic             write_reg_E,
    input  logic             write_reg_M,
    input  logic             write_reg_W,
    input  logic [1:0]       result_source_E,
    input  logic             PC_source_E,
    input  logic             memory_transaction_M,
    input  logic             mem_ready,
    output logic             enable_F,
    output logic             enable_D,
    output logic             enable_E,
    output logic             enable_M,
    output logic             flush_D,
    output logic             flush_E,
    output logic [1:0]       forward_0_E,
    output logic [1:0]       forward_1_E,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

    hz_state_t        state_q, state_d;
    logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

    logic       mem_stall;
    logic       load_use;
    logic       run_rules;
    logic [1:0] fwd0, fwd1;

    forwarding_unit #(.REG_W(REG_W)) u_fwd (
        .r1_E        (r1_E),
        .r2_E        (r2_E),
        .rd_M        (rd_M),
        .rd_W        (rd_W),
        .write_reg_M (write_reg_M),
        .write_reg_W (write_reg_W),
        .forward_0_E (fwd0),
        .forward_1_E (fwd1)
    );

    always_comb begin
        mem_stall = memory_transaction_M && !mem_ready;
        load_use  = (result_source_E == RES_SRC_LOAD) && write_reg_E
                    && rd_E != '0
                    && (r1_D == rd_E || r2_D == rd_E);
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        run_rules  = 1'b0;
        enable_F   = 1'b0;
        enable_D   = 1'b0;
        enable_E   = 1'b0;
        enable_M   = 1'b0;
        flush_D    = 1'b0;
        flush_E    = 1'b0;

        unique case (state_q)
            RUN: begin
                if (mem_stall) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WC_W'(1);
                end else begin
                    run_rules = 1'b1;
                end
            end
            MEM_WAIT: begin
                // Held flushes: a branch in E resolves again once M drains
                if (mem_stall) begin
                    wait_cnt_d = wait_cnt_q + WC_W'(1);
                    if (wait_cnt_q >= WC_W'(MEM_TIMEOUT - 1)) begin
                        state_d = ERROR;
                    end
                end else begin
                    run_rules  = 1'b1;
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end
            end
            ERROR: begin
                state_d = ERROR;
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase

        if (run_rules) begin
            if (PC_source_E) begin
                {enable_F, enable_D, enable_E, enable_M} = 4'b1111;
                flush_D = 1'b1;
                flush_E = 1'b1;
            end else if (load_use) begin
                enable_E = 1'b1;
                enable_M = 1'b1;
                flush_E  = 1'b1;
            end else begin
                {enable_F, enable_D, enable_E, enable_M} = 4'b1111;
            end
        end

        if (sync_reset) begin
            state_d    = RUN;
            wait_cnt_d = '0;
            {enable_F, enable_D, enable_E, enable_M} = 4'b0000;
            flush_D = 1'b1;
            flush_E = 1'b1;
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (sync_reset) begin
            stall_cycles_d = '0;
        end else if (!enable_D && stall_cycles_q != '1) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (sync_reset) begin
            state_q        <= RUN;
            wait_cnt_q     <= '0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    always_comb begin
        forward_0_E  = sync_reset ? FWD_REG : fwd0;
        forward_1_E  = sync_reset ? FWD_REG : fwd1;
        mem_error    = (state_q == ERROR);
        stall_cycles = stall_cycles_q;
    end

endmodule
